// File: rtl/picomips_sequencer_if.sv
// Control/ROM bus between the picoMIPS sequencer and its datapath and program ROM.
// The master side is the sequencer; the slave side is the ROM/datapath.
interface picomips_sequencer_if #(
  parameter int PC_WIDTH = 8
);
  logic [2:0]          opcode;
  logic [PC_WIDTH-1:0] jump_target;
  logic                mul_done;
  logic                in_valid;
  logic [PC_WIDTH-1:0] pc;
  logic [1:0]          ALUFunc;
  logic                imm;
  logic                write;
  logic                wb_sel;
  logic                mul_start;
  logic                in_ack;

  modport master (
    input  opcode, jump_target, mul_done, in_valid,
    output pc, ALUFunc, imm, write, wb_sel, mul_start, in_ack
  );

  modport slave (
    output opcode, jump_target, mul_done, in_valid,
    input  pc, ALUFunc, imm, write, wb_sel, mul_start, in_ack
  );
endinterface

// File: rtl/picomips_sequencer.sv
// Multi-cycle control FSM for picoMIPS: PC, instruction register and the
// multiply / external-input handshakes.
//
//   state | meaning
//   FETCH | latch opcode into ir
//   EXEC  | decode ir, single-cycle ops complete here
//   MULW  | multiplier running, wait for mul_done
//   INW   | wait for in_valid, consume input word
module picomips_sequencer #(
  parameter int PC_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 nReset,
  picomips_sequencer_if.master bus
);

  typedef enum logic [1:0] {FETCH, EXEC, MULW, INW} state_t;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MULI = 3'b100;
  localparam logic [2:0] OP_SUBI = 3'b101;
  localparam logic [2:0] OP_JMP  = 3'b110;
  localparam logic [2:0] OP_IN   = 3'b111;

  state_t              state, state_n;
  logic [2:0]          ir, ir_n;
  logic [PC_WIDTH-1:0] pc, pc_n;
  logic [PC_WIDTH-1:0] pc_inc;

  assign pc_inc = pc + PC_WIDTH'(1);
  assign bus.pc = pc;

  always_ff @(posedge clk) begin
    if (!nReset) begin
      state <= FETCH;
      ir    <= 3'b000;
      pc    <= '0;
    end else begin
      state <= state_n;
      ir    <= ir_n;
      pc    <= pc_n;
    end
  end

  always_comb begin
    state_n       = state;
    ir_n          = ir;
    pc_n          = pc;
    bus.ALUFunc   = 2'b00;
    bus.imm       = 1'b0;
    bus.write     = 1'b0;
    bus.wb_sel    = 1'b0;
    bus.mul_start = 1'b0;
    bus.in_ack    = 1'b0;

    case (state)
      FETCH: begin
        ir_n    = bus.opcode;
        state_n = EXEC;
      end

      EXEC: begin
        case (ir)
          OP_NOP: begin
            pc_n    = pc_inc;
            state_n = FETCH;
          end
          OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
            bus.ALUFunc = (ir == OP_ADD || ir == OP_ADDI) ? 2'b01 : 2'b10;
            bus.imm     = (ir == OP_ADDI || ir == OP_SUBI);
            bus.write   = 1'b1;
            pc_n        = pc_inc;
            state_n     = FETCH;
          end
          OP_MULI: begin
            bus.ALUFunc   = 2'b11;
            bus.imm       = 1'b1;
            bus.mul_start = 1'b1;
            state_n       = MULW;
          end
          OP_JMP: begin
            pc_n    = bus.jump_target;
            state_n = FETCH;
          end
          OP_IN: begin
            state_n = INW;
          end
          default: state_n = FETCH;
        endcase
      end

      // ALU controls stay on so the datapath keeps the product selected
      MULW: begin
        bus.ALUFunc = 2'b11;
        bus.imm     = 1'b1;
        if (bus.mul_done) begin
          bus.write = 1'b1;
          pc_n      = pc_inc;
          state_n   = FETCH;
        end
      end

      INW: begin
        bus.wb_sel = 1'b1;
        if (bus.in_valid) begin
          bus.write  = 1'b1;
          bus.in_ack = 1'b1;
          pc_n       = pc_inc;
          state_n    = FETCH;
        end
      end

      default: state_n = FETCH;
    endcase
  end

endmodule

// File: tb/tb_picomips_sequencer.sv
// Directed bench for picomips_sequencer: a cycle table over a small program
// plus hand-written reset, wrap, jump and halt sequences.
module tb_picomips_sequencer;

  logic clk;
  logic nReset;
  int   checks;
  int   errors;

  picomips_sequencer_if #(.PC_WIDTH(8)) bus ();

  picomips_sequencer #(.PC_WIDTH(8)) dut (
    .clk    (clk),
    .nReset (nReset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rom_op  [256];
  logic [7:0] rom_tgt [256];
  assign bus.opcode      = rom_op[bus.pc];
  assign bus.jump_target = rom_tgt[bus.pc];

  typedef struct {
    logic       md;
    logic       iv;
    logic [7:0] pc;
    logic [1:0] alu;
    logic       imm;
    logic       wr;
    logic       wb;
    logic       ms;
    logic       ack;
  } vec_t;

  vec_t tbl [27];

  function automatic logic [14:0] pack_exp(input logic [7:0] p, input logic [1:0] a,
                                           input logic i, input logic w, input logic b,
                                           input logic m, input logic k);
    return {p, a, i, w, b, m, k};
  endfunction

  task automatic step(input logic md, input logic iv, input logic [14:0] exp, input string nm);
    logic [14:0] got;
    bus.mul_done = md;
    bus.in_valid = iv;
    @(negedge clk);
    got = {bus.pc, bus.ALUFunc, bus.imm, bus.write, bus.wb_sel, bus.mul_start, bus.in_ack};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got {pc,alu,imm,wr,wb,ms,ack}=%h/%b/%b%b%b%b%b expected %h/%b/%b%b%b%b%b",
               nm, got[14:7], got[6:5], got[4], got[3], got[2], got[1], got[0],
               exp[14:7], exp[6:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.mul_done = 1'b0;
    bus.in_valid = 1'b0;
    nReset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    nReset = 1'b1;
  endtask

  // write and mul_start must never be high on two consecutive cycles
  logic prev_wr, prev_ms;
  initial begin
    prev_wr = 1'b0;
    prev_ms = 1'b0;
  end
  always @(negedge clk) begin
    if (nReset === 1'b1) begin
      checks++;
      if (prev_wr && bus.write === 1'b1) begin
        errors++;
        $display("FAIL write_back_to_back: write=1 on consecutive cycles, expected a gap");
      end
      if (prev_ms && bus.mul_start === 1'b1) begin
        errors++;
        $display("FAIL mul_start_back_to_back: mul_start=1 on consecutive cycles, expected a gap");
      end
    end
    prev_wr = (bus.write === 1'b1);
    prev_ms = (bus.mul_start === 1'b1);
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its summary, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    nReset = 1'b0;
    bus.mul_done = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 256; i++) begin
      rom_op[i]  = 3'b000;
      rom_tgt[i] = 8'h00;
    end
    // program: ADD, ADDI, SUB, NOP, NOP, MULI, NOP, IN, JMP 8 (halt)
    rom_op[0] = 3'b001;
    rom_op[1] = 3'b010;
    rom_op[2] = 3'b011;
    rom_op[3] = 3'b000;
    rom_op[4] = 3'b000;
    rom_op[5] = 3'b100;
    rom_op[6] = 3'b000;
    rom_op[7] = 3'b111;
    rom_op[8] = 3'b110;
    rom_tgt[8] = 8'h08;

    //           md    iv    pc     alu    imm wr  wb  ms  ack
    tbl[0]  = '{1'b0, 1'b0, 8'h00, 2'b00, 0, 0, 0, 0, 0};
    tbl[1]  = '{1'b0, 1'b0, 8'h00, 2'b01, 0, 1, 0, 0, 0};
    tbl[2]  = '{1'b0, 1'b0, 8'h01, 2'b00, 0, 0, 0, 0, 0};
    tbl[3]  = '{1'b0, 1'b0, 8'h01, 2'b01, 1, 1, 0, 0, 0};
    tbl[4]  = '{1'b0, 1'b0, 8'h02, 2'b00, 0, 0, 0, 0, 0};
    tbl[5]  = '{1'b0, 1'b0, 8'h02, 2'b10, 0, 1, 0, 0, 0};
    tbl[6]  = '{1'b0, 1'b0, 8'h03, 2'b00, 0, 0, 0, 0, 0};
    tbl[7]  = '{1'b0, 1'b0, 8'h03, 2'b00, 0, 0, 0, 0, 0};
    tbl[8]  = '{1'b1, 1'b1, 8'h04, 2'b00, 0, 0, 0, 0, 0};
    tbl[9]  = '{1'b1, 1'b1, 8'h04, 2'b00, 0, 0, 0, 0, 0};
    tbl[10] = '{1'b0, 1'b0, 8'h05, 2'b00, 0, 0, 0, 0, 0};
    tbl[11] = '{1'b0, 1'b0, 8'h05, 2'b11, 1, 0, 0, 1, 0};
    tbl[12] = '{1'b0, 1'b0, 8'h05, 2'b11, 1, 0, 0, 0, 0};
    tbl[13] = '{1'b0, 1'b0, 8'h05, 2'b11, 1, 0, 0, 0, 0};
    tbl[14] = '{1'b1, 1'b0, 8'h05, 2'b11, 1, 1, 0, 0, 0};
    tbl[15] = '{1'b0, 1'b1, 8'h06, 2'b00, 0, 0, 0, 0, 0};
    tbl[16] = '{1'b0, 1'b0, 8'h06, 2'b00, 0, 0, 0, 0, 0};
    tbl[17] = '{1'b0, 1'b0, 8'h07, 2'b00, 0, 0, 0, 0, 0};
    tbl[18] = '{1'b0, 1'b0, 8'h07, 2'b00, 0, 0, 0, 0, 0};
    tbl[19] = '{1'b0, 1'b0, 8'h07, 2'b00, 0, 0, 1, 0, 0};
    tbl[20] = '{1'b0, 1'b0, 8'h07, 2'b00, 0, 0, 1, 0, 0};
    tbl[21] = '{1'b0, 1'b0, 8'h07, 2'b00, 0, 0, 1, 0, 0};
    tbl[22] = '{1'b0, 1'b0, 8'h07, 2'b00, 0, 0, 1, 0, 0};
    tbl[23] = '{1'b0, 1'b1, 8'h07, 2'b00, 0, 1, 1, 0, 1};
    tbl[24] = '{1'b0, 1'b0, 8'h08, 2'b00, 0, 0, 0, 0, 0};
    tbl[25] = '{1'b0, 1'b0, 8'h08, 2'b00, 0, 0, 0, 0, 0};
    tbl[26] = '{1'b0, 1'b0, 8'h08, 2'b00, 0, 0, 0, 0, 0};

    do_reset();
    for (int i = 0; i < 27; i++) begin
      step(tbl[i].md, tbl[i].iv,
           pack_exp(tbl[i].pc, tbl[i].alu, tbl[i].imm, tbl[i].wr, tbl[i].wb, tbl[i].ms, tbl[i].ack),
           $sformatf("prog_cycle_%0d", i));
    end

    // halt idiom: JMP 8 at pc 8 keeps pc constant and never writes
    for (int i = 0; i < 20; i++)
      step(1'b0, 1'b0, pack_exp(8'h08, 2'b00, 0, 0, 0, 0, 0), $sformatf("halt_%0d", i));

    // JMP at 0xFF to 0x20
    rom_op[0] = 3'b110; rom_tgt[0] = 8'hFF;
    rom_op[255] = 3'b110; rom_tgt[255] = 8'h20;
    do_reset();
    step(1'b0, 1'b0, pack_exp(8'h00, 2'b00, 0, 0, 0, 0, 0), "jmp_fetch0");
    step(1'b0, 1'b0, pack_exp(8'h00, 2'b00, 0, 0, 0, 0, 0), "jmp_exec0");
    step(1'b0, 1'b0, pack_exp(8'hFF, 2'b00, 0, 0, 0, 0, 0), "jmp_fetchff");
    step(1'b0, 1'b0, pack_exp(8'hFF, 2'b00, 0, 0, 0, 0, 0), "jmp_execff_nowrite");
    step(1'b0, 1'b0, pack_exp(8'h20, 2'b00, 0, 0, 0, 0, 0), "jmp_target_20");

    // NOP at 0xFF wraps pc to 0
    rom_op[255] = 3'b000;
    do_reset();
    step(1'b0, 1'b0, pack_exp(8'h00, 2'b00, 0, 0, 0, 0, 0), "wrap_fetch0");
    step(1'b0, 1'b0, pack_exp(8'h00, 2'b00, 0, 0, 0, 0, 0), "wrap_exec0");
    step(1'b0, 1'b0, pack_exp(8'hFF, 2'b00, 0, 0, 0, 0, 0), "wrap_fetchff");
    step(1'b0, 1'b0, pack_exp(8'hFF, 2'b00, 0, 0, 0, 0, 0), "wrap_execff");
    step(1'b0, 1'b0, pack_exp(8'h00, 2'b00, 0, 0, 0, 0, 0), "wrap_pc00");

    // reset in the middle of a MULW wait, then a late mul_done
    rom_op[0] = 3'b100; rom_tgt[0] = 8'h00;
    rom_op[1] = 3'b000;
    do_reset();
    step(1'b0, 1'b0, pack_exp(8'h00, 2'b00, 0, 0, 0, 0, 0), "rst_mul_fetch");
    step(1'b0, 1'b0, pack_exp(8'h00, 2'b11, 1, 0, 0, 1, 0), "rst_mul_exec");
    nReset = 1'b0;
    step(1'b0, 1'b0, pack_exp(8'h00, 2'b11, 1, 0, 0, 0, 0), "rst_mul_wait");
    nReset = 1'b1;
    step(1'b1, 1'b0, pack_exp(8'h00, 2'b00, 0, 0, 0, 0, 0), "rst_late_done_nowrite");
    step(1'b0, 1'b0, pack_exp(8'h00, 2'b11, 1, 0, 0, 1, 0), "rst_restart_exec0");
    step(1'b1, 1'b0, pack_exp(8'h00, 2'b11, 1, 1, 0, 0, 0), "rst_restart_done");
    step(1'b0, 1'b0, pack_exp(8'h01, 2'b00, 0, 0, 0, 0, 0), "rst_restart_pc1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
